// File: rtl/hs_vector_driver.sv
// rtl/hs_vector_driver.sv - operand-pair sequencer for stb/ack handshake datapaths
// Plays stored operand pairs into a DUT one at a time and streams back each result.
module hs_vector_driver #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255,
  parameter int GAP     = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  input  logic [AW:0]      num_vec,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [AW:0]      vec_count,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_a_stb,
  output logic             dut_b_stb,
  input  logic             dut_a_ack,
  input  logic             dut_b_ack,
  input  logic [WIDTH-1:0] dut_z,
  input  logic             dut_z_stb,
  output logic             dut_z_ack,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [AW-1:0]    res_index
);

  localparam int TW       = $clog2(TIMEOUT + 1);
  localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_Z, S_ACK, S_GAP, S_DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];

  logic [AW-1:0]    idx;
  logic [AW:0]      n_vec;
  logic [TW-1:0]    tcnt;
  logic [GW-1:0]    gcnt;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] issue_a, issue_b;
  logic             a_ok, b_ok, timeout_hit, last_vec, bypass, issue_entry;
  logic             busy_d, done_d, z_ack_d, res_valid_d, a_stb_d, b_stb_d;

  assign a_ok        = !dut_a_stb || dut_a_ack;
  assign b_ok        = !dut_b_stb || dut_b_ack;
  assign timeout_hit = (state == S_ISSUE || state == S_WAIT_Z) && (tcnt == TW'(TIMEOUT - 1));
  assign last_vec    = (vec_count + 1'b1) == n_vec;
  assign issue_entry = (state_next == S_ISSUE) && (state != S_ISSUE);

  // The ACK edge fetches the next entry before idx has advanced; a load in the
  // start cycle is forwarded so the run sees the entry written alongside start.
  assign rd_addr = (state == S_ACK) ? idx + 1'b1 : ((state == S_IDLE) ? '0 : idx);
  assign bypass  = (state == S_IDLE) && load_en && (load_addr == rd_addr);
  assign issue_a = bypass ? load_a : mem_a[rd_addr];
  assign issue_b = bypass ? load_b : mem_b[rd_addr];

  always_ff @(posedge clk) begin
    if (rst && load_en && state == S_IDLE) begin
      mem_a[load_addr] <= load_a;
      mem_b[load_addr] <= load_b;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = (num_vec == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:  if (timeout_hit) state_next = S_DONE;
                else if (a_ok && b_ok) state_next = S_WAIT_Z;
      S_WAIT_Z: if (timeout_hit) state_next = S_DONE;
                else if (dut_z_stb) state_next = S_ACK;
      S_ACK:    if (last_vec) state_next = S_DONE;
                else state_next = (GAP > 0) ? S_GAP : S_ISSUE;
      S_GAP:    if (gcnt == GW'(GAP_LAST)) state_next = S_ISSUE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output values are decoded from the next state so every port is a flop.
  always_comb begin
    busy_d      = state_next != S_IDLE;
    done_d      = state_next == S_DONE;
    z_ack_d     = state_next == S_ACK;
    res_valid_d = (state == S_WAIT_Z) && (state_next == S_ACK);
    a_stb_d     = 1'b0;
    b_stb_d     = 1'b0;
    if (issue_entry) begin
      a_stb_d = 1'b1;
      b_stb_d = 1'b1;
    end else if (state == S_ISSUE && state_next == S_ISSUE) begin
      a_stb_d = dut_a_stb && !dut_a_ack;
      b_stb_d = dut_b_stb && !dut_b_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      vec_count   <= '0;
      dut_a       <= '0;
      dut_b       <= '0;
      dut_a_stb   <= 1'b0;
      dut_b_stb   <= 1'b0;
      dut_z_ack   <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_index   <= '0;
      idx         <= '0;
      n_vec       <= '0;
      tcnt        <= '0;
      gcnt        <= '0;
    end else begin
      state     <= state_next;
      busy      <= busy_d;
      done      <= done_d;
      dut_a_stb <= a_stb_d;
      dut_b_stb <= b_stb_d;
      dut_z_ack <= z_ack_d;
      res_valid <= res_valid_d;
      gcnt      <= (state == S_GAP) ? gcnt + 1'b1 : '0;
      if (state == S_IDLE && start) begin
        idx         <= '0;
        vec_count   <= '0;
        timeout_err <= 1'b0;
        n_vec       <= (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
      end
      if (issue_entry) begin
        dut_a <= issue_a;
        dut_b <= issue_b;
        tcnt  <= '0;
      end else if (state == S_ISSUE || state == S_WAIT_Z) begin
        tcnt <= tcnt + 1'b1;
      end
      if (timeout_hit) timeout_err <= 1'b1;
      if (res_valid_d) begin
        res_data  <= dut_z;
        res_index <= idx;
      end
      if (state == S_ACK) begin
        vec_count <= vec_count + 1'b1;
        idx       <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hs_vector_driver.sv
// tb/tb_hs_vector_driver.sv - self-checking bench for hs_vector_driver
// Mock handshake DUT with programmable latencies; results checked through a scoreboard.
module tb_hs_vector_driver;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst, load_en, start;
  logic [AW-1:0]    load_addr;
  logic [WIDTH-1:0] load_a, load_b;
  logic [AW:0]      num_vec;
  logic             busy, done, timeout_err;
  logic [AW:0]      vec_count;
  logic [WIDTH-1:0] dut_a, dut_b, dut_z, res_data;
  logic             dut_a_stb, dut_b_stb, dut_a_ack, dut_b_ack, dut_z_stb, dut_z_ack, res_valid;
  logic [AW-1:0]    res_index;

  always #5 clk = ~clk;

  hs_vector_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(8), .GAP(3)) u_dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_a(load_a),
    .load_b(load_b), .num_vec(num_vec), .start(start), .busy(busy), .done(done),
    .timeout_err(timeout_err), .vec_count(vec_count), .dut_a(dut_a), .dut_b(dut_b),
    .dut_a_stb(dut_a_stb), .dut_b_stb(dut_b_stb), .dut_a_ack(dut_a_ack), .dut_b_ack(dut_b_ack),
    .dut_z(dut_z), .dut_z_stb(dut_z_stb), .dut_z_ack(dut_z_ack), .res_valid(res_valid),
    .res_data(res_data), .res_index(res_index)
  );

  typedef struct packed {logic [AW-1:0] idx; logic [WIDTH-1:0] data;} exp_t;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] ma [DEPTH];
  logic [WIDTH-1:0] mb [DEPTH];
  exp_t exp_q[$];
  exp_t e;

  int a_lat, b_lat, z_lat, a_wait, b_wait, z_wait;
  bit z_never, a_got, b_got, z_on;
  logic [WIDTH-1:0] cap_a, cap_b;
  logic [WIDTH-1:0] mock_z_q[$], cap_a_q[$], cap_b_q[$];

  int res_cnt = 0, done_cnt = 0, zack_cnt = 0, zack_long = 0, zack_len = 0;
  int split_cnt = 0, rerise_cnt = 0, gap_idle = 0;
  bit prev_a = 0, prev_b = 0, gap_meas = 0;
  int gap_q[$];

  // Mock stb/ack datapath: acks each operand after its latency, then returns a result.
  initial begin
    dut_a_ack = 0; dut_b_ack = 0; dut_z_stb = 0; dut_z = '0;
    forever begin
      @(negedge clk);
      dut_a_ack = 0;
      dut_b_ack = 0;
      if (z_on) begin
        if (dut_z_ack) begin
          dut_z_stb = 0; z_on = 0; a_got = 0; b_got = 0; a_wait = 0; b_wait = 0; z_wait = 0;
        end
      end else if (a_got && b_got) begin
        if (!z_never) begin
          if (z_wait >= z_lat) begin
            if (mock_z_q.size() > 0) dut_z = mock_z_q.pop_front();
            else dut_z = cap_a + cap_b;
            dut_z_stb = 1;
            z_on = 1;
          end else z_wait++;
        end
      end else begin
        if (dut_a_stb && !a_got) begin
          if (a_wait >= a_lat) begin
            dut_a_ack = 1; a_got = 1; cap_a = dut_a; cap_a_q.push_back(dut_a);
          end else a_wait++;
        end
        if (dut_b_stb && !b_got) begin
          if (b_wait >= b_lat) begin
            dut_b_ack = 1; b_got = 1; cap_b = dut_b; cap_b_q.push_back(dut_b);
          end else b_wait++;
        end
      end
    end
  end

  // Output monitor: scoreboard pop on res_valid plus event counters.
  initial begin
    forever begin
      @(negedge clk);
      if (res_valid) begin
        res_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL res_unexpected: got idx=%0d data=%h, want no result", res_index, res_data);
        end else begin
          e = exp_q.pop_front();
          if (res_index !== e.idx || res_data !== e.data) begin
            bad++;
            $display("FAIL res_scoreboard: got idx=%0d data=%h, want idx=%0d data=%h",
                     res_index, res_data, e.idx, e.data);
          end
        end
      end
      if (done) done_cnt++;
      if (dut_z_ack) begin
        zack_len++;
        if (zack_len == 1) zack_cnt++;
        if (zack_len == 2) zack_long++;
      end else zack_len = 0;
      if (dut_b_stb && !dut_a_stb) split_cnt++;
      if (dut_a_stb && !prev_a && prev_b) rerise_cnt++;
      prev_a = dut_a_stb;
      prev_b = dut_b_stb;
      if (dut_z_ack) begin
        gap_meas = 1; gap_idle = 0;
      end else if (done) gap_meas = 0;
      else if (gap_meas) begin
        if (dut_a_stb || dut_b_stb) begin
          gap_q.push_back(gap_idle); gap_meas = 0;
        end else gap_idle++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mock_clear();
    a_lat = 0; b_lat = 0; z_lat = 1; z_never = 0;
    a_got = 0; b_got = 0; z_on = 0; a_wait = 0; b_wait = 0; z_wait = 0;
    dut_z_stb = 0;
    mock_z_q.delete(); cap_a_q.delete(); cap_b_q.delete();
  endtask

  task automatic load_entry(input logic [AW-1:0] addr, input logic [WIDTH-1:0] va,
                            input logic [WIDTH-1:0] vb);
    load_en = 1; load_addr = addr; load_a = va; load_b = vb;
    tick();
    load_en = 0;
  endtask

  task automatic push_exp(input int i);
    exp_q.push_back('{idx: AW'(i), data: ma[i] + mb[i]});
  endtask

  task automatic run_start(input logic [AW:0] nv);
    num_vec = nv; start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen = 0;
    while (cycles < budget && !seen) begin
      if (done) seen = 1;
      else begin
        tick();
        cycles++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 0; load_en = 0; start = 0; num_vec = '0; load_addr = '0; load_a = '0; load_b = '0;
    mock_clear();
    repeat (3) tick();
    total++;
    if ({busy, done, timeout_err, res_valid, dut_a_stb, dut_b_stb, dut_z_ack} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0", {busy, done, timeout_err, res_valid, dut_a_stb, dut_b_stb, dut_z_ack});
    end
    total++;
    if (vec_count !== '0 || res_index !== '0) begin
      bad++; $display("FAIL reset_counts: got vc=%0d idx=%0d want 0", vec_count, res_index);
    end
    total++;
    if (res_data !== '0 || dut_a !== '0 || dut_b !== '0) begin
      bad++; $display("FAIL reset_data: got %h %h %h want 0", res_data, dut_a, dut_b);
    end
    rst = 1;
    tick();
  endtask

  task automatic test_basic();
    int cyc, d0;
    bit seen;
    mock_clear();
    a_lat = 1; b_lat = 1; z_lat = 1;
    load_entry(0, 32'h3F80_0000, 32'h4000_0000); ma[0] = 32'h3F80_0000; mb[0] = 32'h4000_0000;
    load_entry(1, 32'h4040_0000, 32'h3F80_0000); ma[1] = 32'h4040_0000; mb[1] = 32'h3F80_0000;
    mock_z_q.push_back(32'h4040_0000); mock_z_q.push_back(32'h4080_0000);
    exp_q.push_back('{idx: 3'd0, data: 32'h4040_0000});
    exp_q.push_back('{idx: 3'd1, data: 32'h4080_0000});
    d0 = done_cnt;
    run_start(2);
    total++;
    if (dut_a_stb !== 1'b1 || dut_b_stb !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_stb_rise: got a=%b b=%b busy=%b want 1", dut_a_stb, dut_b_stb, busy);
    end
    wait_done(80, cyc, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL basic_done: got no done want done"); end
    tick();
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    total++;
    if (vec_count !== 4'd2 || timeout_err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_status: got vc=%0d te=%b busy=%b want 2 0 0", vec_count, timeout_err, busy);
    end
    total++;
    if (cap_a_q.size() != 2 || cap_b_q.size() != 2) begin
      bad++; $display("FAIL basic_operand_count: got %0d/%0d want 2/2", cap_a_q.size(), cap_b_q.size());
    end else if (cap_a_q[0] !== 32'h3F80_0000 || cap_b_q[0] !== 32'h4000_0000 ||
                 cap_a_q[1] !== 32'h4040_0000 || cap_b_q[1] !== 32'h3F80_0000) begin
      bad++;
      $display("FAIL basic_operands: got %h %h %h %h want 3f800000 40000000 40400000 3f800000",
               cap_a_q[0], cap_b_q[0], cap_a_q[1], cap_b_q[1]);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL basic_results: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_split_ack();
    int cyc, s0, r0, z0, l0;
    bit seen;
    mock_clear();
    a_lat = 1; b_lat = 4; z_lat = 0;
    s0 = split_cnt; r0 = rerise_cnt; z0 = zack_cnt; l0 = zack_long;
    push_exp(0); push_exp(1);
    run_start(2);
    wait_done(80, cyc, seen);
    tick();
    total++;
    if (!seen || split_cnt == s0) begin
      bad++; $display("FAIL split_a_drop: got seen=%b split_cycles=%0d want done and >0", seen, split_cnt - s0);
    end
    total++;
    if (rerise_cnt != r0) begin bad++; $display("FAIL split_a_rerise: got %0d want 0", rerise_cnt - r0); end
    total++;
    if (zack_cnt - z0 != 2 || zack_long != l0) begin
      bad++; $display("FAIL split_zack: got pulses=%0d long=%0d want 2 0", zack_cnt - z0, zack_long - l0);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL split_results: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int cyc;
    bit seen;
    mock_clear();
    z_never = 1;
    load_entry(2, 32'h0000_1111, 32'h0000_2222); ma[2] = 32'h0000_1111; mb[2] = 32'h0000_2222;
    run_start(1);
    wait_done(30, cyc, seen);
    total++;
    if (!seen || cyc != 8) begin bad++; $display("FAIL timeout_latency: got seen=%b cycles=%0d want 1 8", seen, cyc); end
    total++;
    if (timeout_err !== 1'b1 || vec_count !== '0 || {dut_a_stb, dut_b_stb, dut_z_ack} !== 3'b0) begin
      bad++;
      $display("FAIL timeout_status: got te=%b vc=%0d stbs=%b want 1 0 000", timeout_err, vec_count,
               {dut_a_stb, dut_b_stb, dut_z_ack});
    end
    tick();
    mock_clear();
    push_exp(0);
    run_start(1);
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
    wait_done(60, cyc, seen);
    tick();
    total++;
    if (!seen || vec_count !== 4'd1 || timeout_err !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL timeout_rerun: got seen=%b vc=%0d te=%b pending=%0d want 1 1 0 0", seen, vec_count,
               timeout_err, exp_q.size());
    end
  endtask

  task automatic test_zero_and_over();
    int cyc, d0, r0;
    bit seen;
    mock_clear();
    d0 = done_cnt;
    run_start(0);
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || {dut_a_stb, dut_b_stb} !== 2'b0) begin
      bad++; $display("FAIL zero_done: got done=%b busy=%b stbs=%b want 1 1 00", done, busy, {dut_a_stb, dut_b_stb});
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1 || vec_count !== '0) begin
      bad++; $display("FAIL zero_after: got done=%b busy=%b pulses=%0d vc=%0d want 0 0 1 0", done, busy, done_cnt - d0, vec_count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      ma[i] = $urandom; mb[i] = $urandom;
      load_entry(AW'(i), ma[i], mb[i]);
    end
    for (int i = 0; i < DEPTH; i++) push_exp(i);
    b_lat = 1;
    r0 = res_cnt;
    run_start(4'(DEPTH + 5));
    wait_done(400, cyc, seen);
    tick();
    total++;
    if (!seen || vec_count !== 4'(DEPTH) || res_cnt - r0 != DEPTH || exp_q.size() != 0) begin
      bad++;
      $display("FAIL over_depth: got seen=%b vc=%0d results=%0d pending=%0d want 1 %0d %0d 0", seen, vec_count,
               res_cnt - r0, exp_q.size(), DEPTH, DEPTH);
    end
  endtask

  task automatic test_gap_and_load();
    int cyc;
    bit seen;
    mock_clear();
    gap_q.delete();
    push_exp(0); push_exp(1); push_exp(2);
    run_start(3);
    tick(); tick();
    load_entry(0, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_done(200, cyc, seen);
    tick();
    total++;
    if (!seen || gap_q.size() != 2) begin
      bad++; $display("FAIL gap_count: got seen=%b gaps=%0d want 1 2", seen, gap_q.size());
    end
    foreach (gap_q[i]) begin
      total++;
      if (gap_q[i] != 3) begin bad++; $display("FAIL gap_len: got %0d want 3", gap_q[i]); end
    end
    mock_clear();
    push_exp(0);
    run_start(1);
    wait_done(60, cyc, seen);
    tick();
    total++;
    if (cap_a_q.size() != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL load_busy_ignored: got ops=%0d pending=%0d want 1 0", cap_a_q.size(), exp_q.size());
    end else if (cap_a_q[0] !== ma[0]) begin
      bad++; $display("FAIL load_busy_ignored: got a=%h want %h", cap_a_q[0], ma[0]);
    end
  endtask

  task automatic test_load_with_start();
    int cyc;
    bit seen;
    mock_clear();
    ma[0] = 32'h0ABC_0001; mb[0] = 32'h0000_0100;
    push_exp(0);
    load_en = 1; load_addr = '0; load_a = ma[0]; load_b = mb[0];
    num_vec = 1; start = 1;
    tick();
    load_en = 0; start = 0;
    wait_done(60, cyc, seen);
    tick();
    total++;
    if (!seen || cap_a_q.size() != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL load_start: got seen=%b ops=%0d pending=%0d want 1 1 0", seen, cap_a_q.size(), exp_q.size());
    end else if (cap_a_q[0] !== ma[0] || cap_b_q[0] !== mb[0]) begin
      bad++; $display("FAIL load_start_ops: got %h %h want %h %h", cap_a_q[0], cap_b_q[0], ma[0], mb[0]);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc, d0;
    bit seen;
    mock_clear();
    z_lat = 20;
    d0 = done_cnt;
    run_start(2);
    tick(); tick();
    total++;
    if (busy !== 1'b1 || dut_a_stb !== 1'b0 || res_data === '0) begin
      bad++; $display("FAIL midrun_wait_z: got busy=%b a_stb=%b res=%h want 1 0 nonzero", busy, dut_a_stb, res_data);
    end
    rst = 0;
    tick();
    total++;
    if ({busy, done, timeout_err, res_valid, dut_a_stb, dut_b_stb, dut_z_ack} !== 7'b0 ||
        vec_count !== '0 || res_data !== '0 || res_index !== '0 || dut_a !== '0) begin
      bad++;
      $display("FAIL midrun_reset: got flags=%b vc=%0d res=%h want all 0",
               {busy, done, timeout_err, res_valid, dut_a_stb, dut_b_stb, dut_z_ack}, vec_count, res_data);
    end
    rst = 1;
    mock_clear();
    repeat (3) tick();
    total++;
    if (done_cnt != d0) begin bad++; $display("FAIL midrun_no_done: got %0d pulses want 0", done_cnt - d0); end
    push_exp(0);
    run_start(1);
    wait_done(60, cyc, seen);
    tick();
    total++;
    if (!seen || cap_a_q.size() != 1 || exp_q.size() != 0 || vec_count !== 4'd1) begin
      bad++;
      $display("FAIL midrun_restart: got seen=%b ops=%0d pending=%0d vc=%0d want 1 1 0 1", seen, cap_a_q.size(),
               exp_q.size(), vec_count);
    end else if (cap_a_q[0] !== ma[0]) begin
      bad++; $display("FAIL midrun_restart_idx: got a=%h want %h", cap_a_q[0], ma[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split_ack();
    test_timeout();
    test_zero_and_over();
    test_gap_and_load();
    test_load_with_start();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
